// File: rtl/byte_lane_unit.sv
// byte_lane_unit
// Lane extract/insert unit with a two-stage valid/ready pipeline.
//   GETZ : zero-extended lane idx of opb
//   GETS : sign-extended lane idx of opb
//   PUT  : opd with lane idx replaced by opb[LANE-1:0]
//   REV  : opb with lane order reversed (idx ignored)
// An out-of-range idx gives res = 0 for GETZ/GETS and res = opd for PUT.
// It also raises oor.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   op, opd, opb, idx     request fields
//   out_valid / out_ready result handshake
//   res, zf, oor          result, zero flag, index-out-of-range flag
module byte_lane_unit #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opd,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             oor
);
    localparam int NL   = WIDTH / LANE;
    localparam int IDXW = (NL > 1) ? $clog2(NL) : 1;

    localparam logic [1:0] OP_GETZ = 2'b00;
    localparam logic [1:0] OP_GETS = 2'b01;
    localparam logic [1:0] OP_PUT  = 2'b10;
    localparam logic [1:0] OP_REV  = 2'b11;

    // Stage 1 registers
    logic            r_s1_valid;
    logic [1:0]      r_s1_op;
    logic [WIDTH-1:0] r_s1_opd;
    logic [WIDTH-1:0] r_s1_opb;
    logic            r_s1_bad;
    logic [IDXW-1:0] r_s1_idx;

    // Stage 2 registers
    logic            r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic            r_s2_zf;
    logic            r_s2_oor;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_bad;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = !reset && w_s1_adv;

    // The full-width compare also catches any set bit above the truncated index.
    assign w_in_bad = (idx >= WIDTH'(NL));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op  <= op;
                r_s1_opd <= opd;
                r_s1_opb <= opb;
                r_s1_bad <= w_in_bad;
                r_s1_idx <= idx[IDXW-1:0];
            end
        end
    end

    // Lane view and reversed word of the stage-1 source operand
    logic [LANE-1:0]  w_lane [NL];
    logic [WIDTH-1:0] w_rev;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            assign w_lane[gi] = r_s1_opb[gi*LANE +: LANE];
            assign w_rev[gi*LANE +: LANE] = r_s1_opb[(NL-1-gi)*LANE +: LANE];
        end
    endgenerate

    logic [LANE-1:0]  w_sel;
    logic [WIDTH-1:0] w_put;
    logic [WIDTH-1:0] w_res;
    logic             w_oor;

    always_comb begin
        w_sel = '0;
        w_put = r_s1_opd;
        // A decoded mux avoids indexing past NL when NL is not a power of two.
        for (int k = 0; k < NL; k++) begin
            if (r_s1_idx == IDXW'(k)) begin
                w_sel = w_lane[k];
                if (!r_s1_bad) begin
                    w_put[k*LANE +: LANE] = r_s1_opb[LANE-1:0];
                end
            end
        end
        w_oor = 1'b0;
        case (r_s1_op)
            OP_GETZ: begin
                w_res = r_s1_bad ? '0 : {{(WIDTH-LANE){1'b0}}, w_sel};
                w_oor = r_s1_bad;
            end
            OP_GETS: begin
                w_res = r_s1_bad ? '0 : {{(WIDTH-LANE){w_sel[LANE-1]}}, w_sel};
                w_oor = r_s1_bad;
            end
            OP_PUT: begin
                w_res = w_put;
                w_oor = r_s1_bad;
            end
            default: begin
                w_res = w_rev;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_zf    <= 1'b0;
            r_s2_oor   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= w_res;
                r_s2_zf  <= (w_res == '0);
                r_s2_oor <= w_oor;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign res       = r_s2_res;
    assign zf        = r_s2_zf;
    assign oor       = r_s2_oor;

endmodule
